// File: rtl/interrupt_controller_pkg.sv
// Shared types and sizing for the three-level nested interrupt controller.
package interrupt_controller_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    TAKE = 1'b1
  } state_e;

  localparam int LVL_W       = 2;
  localparam int STACK_DEPTH = 3;
  localparam int NUM_SRC     = 3;

endpackage

// File: rtl/interrupt_controller_irq_stack.sv
// Return stack of {pc, level} entries; top reads as all-zero when empty.
module irq_stack
  import interrupt_controller_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [PC_W-1:0]  push_pc_i,
  input  logic [LVL_W-1:0] push_lvl_i,
  output logic [PC_W-1:0]  top_pc_o,
  output logic [LVL_W-1:0] top_lvl_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [PC_W-1:0]  pc_q  [STACK_DEPTH];
  logic [LVL_W-1:0] lvl_q [STACK_DEPTH];
  logic [1:0]       count_q;
  logic [1:0]       top_idx;

  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'(STACK_DEPTH));
  assign top_idx = count_q - 2'd1;

  always_comb begin
    top_pc_o  = '0;
    top_lvl_o = '0;
    if (!empty_o) begin
      top_pc_o  = pc_q[top_idx];
      top_lvl_o = lvl_q[top_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        pc_q[i]  <= '0;
        lvl_q[i] <= '0;
      end
    end else if (push_i && !full_o) begin
      pc_q[count_q]  <= push_pc_i;
      lvl_q[count_q] <= push_lvl_i;
      count_q        <= count_q + 2'd1;
    end else if (pop_i && !empty_o) begin
      count_q <= count_q - 2'd1;
    end
  end

  // Strictly-increasing nesting bounds depth at the number of levels.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push_i && full_o));
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-triggered, three-level priority interrupt controller with nested return stack.
//   state | meaning
//   RUN   | normal execution; takes/returns evaluated at instruction boundaries
//   TAKE  | int_take asserted; CPU is loading int_vector, boundaries ignored
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int              PC_W       = 32,
  parameter logic [PC_W-1:0] VEC_BASE   = PC_W'(32'h0000_0100),
  parameter logic [PC_W-1:0] VEC_STRIDE = PC_W'(32'h0000_0040)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               ie,
  input  logic               instr_done,
  input  logic               eret,
  input  logic [PC_W-1:0]    next_pc,
  output logic               int_take,
  output logic [PC_W-1:0]    int_vector,
  output logic [PC_W-1:0]    ret_pc,
  output logic [LVL_W-1:0]   active_level,
  output logic [NUM_SRC-1:0] pending
);

  state_e             state_q;
  logic [NUM_SRC-1:0] irq_prev_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [LVL_W-1:0]   active_q;
  logic               int_take_q;
  logic [PC_W-1:0]    int_vector_q;

  logic [LVL_W-1:0]   pend_lvl;
  logic [LVL_W-1:0]   lvl_m1;
  logic [NUM_SRC-1:0] clr_mask;
  logic               take_cond;
  logic               pop_cond;
  logic [PC_W-1:0]    top_pc;
  logic [LVL_W-1:0]   top_lvl;
  logic               stk_empty;
  logic               stk_full;

  always_comb begin
    pend_lvl = 2'd0;
    if (pending_q[2])      pend_lvl = 2'd3;
    else if (pending_q[1]) pend_lvl = 2'd2;
    else if (pending_q[0]) pend_lvl = 2'd1;
  end

  assign lvl_m1    = pend_lvl - 2'd1;
  assign take_cond = (state_q == RUN) && ie && instr_done && !eret && (pend_lvl > active_q);
  assign pop_cond  = (state_q == RUN) && instr_done && eret && !stk_empty;
  assign clr_mask  = take_cond ? (3'b001 << lvl_m1) : 3'b000;
  // New edges are OR-ed after the clear so a re-request during its own take survives.
  assign pending_d = (pending_q & ~clr_mask) | (irq_src & ~irq_prev_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      irq_prev_q   <= irq_src;
      pending_q    <= '0;
      active_q     <= '0;
      int_take_q   <= 1'b0;
      int_vector_q <= '0;
    end else begin
      irq_prev_q <= irq_src;
      pending_q  <= pending_d;
      int_take_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (take_cond) begin
            state_q      <= TAKE;
            active_q     <= pend_lvl;
            int_take_q   <= 1'b1;
            int_vector_q <= VEC_BASE + PC_W'(lvl_m1) * VEC_STRIDE;
          end else if (pop_cond) begin
            active_q <= top_lvl;
          end
        end
        TAKE:    state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  irq_stack #(.PC_W(PC_W)) u_stack (
    .clk        (clk),
    .rst        (rst),
    .push_i     (take_cond),
    .pop_i      (pop_cond),
    .push_pc_i  (next_pc),
    .push_lvl_i (active_q),
    .top_pc_o   (top_pc),
    .top_lvl_o  (top_lvl),
    .empty_o    (stk_empty),
    .full_o     (stk_full)
  );

  assign int_take     = int_take_q;
  assign int_vector   = int_vector_q;
  assign ret_pc       = top_pc;
  assign active_level = active_q;
  assign pending      = pending_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed testbench for interrupt_controller with hand-computed expectations.
module tb_interrupt_controller;

  logic        clk;
  logic        rst;
  logic [2:0]  irq_src;
  logic        ie;
  logic        instr_done;
  logic        eret;
  logic [31:0] next_pc;
  logic        int_take;
  logic [31:0] int_vector;
  logic [31:0] ret_pc;
  logic [1:0]  active_level;
  logic [2:0]  pending;

  int checks;
  int failures;

  interrupt_controller dut (
    .clk          (clk),
    .rst          (rst),
    .irq_src      (irq_src),
    .ie           (ie),
    .instr_done   (instr_done),
    .eret         (eret),
    .next_pc      (next_pc),
    .int_take     (int_take),
    .int_vector   (int_vector),
    .ret_pc       (ret_pc),
    .active_level (active_level),
    .pending      (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    instr_done = 1'b0;
    eret       = 1'b0;
  endtask

  task automatic do_reset(input logic [2:0] src);
    rst = 1'b1; irq_src = src; ie = 1'b1; instr_done = 1'b0; eret = 1'b0; next_pc = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(3'b000);
    checks++; if (int_take !== 1'b0) begin failures++; $display("FAIL rst_take got=%0b exp=0", int_take); end
    checks++; if (int_vector !== 32'h0) begin failures++; $display("FAIL rst_vector got=%h exp=0", int_vector); end
    checks++; if (ret_pc !== 32'h0) begin failures++; $display("FAIL rst_ret_pc got=%h exp=0", ret_pc); end
    checks++; if (active_level !== 2'd0) begin failures++; $display("FAIL rst_active got=%0d exp=0", active_level); end
    checks++; if (pending !== 3'b000) begin failures++; $display("FAIL rst_pending got=%b exp=000", pending); end
  endtask

  task automatic test_single_take();
    do_reset(3'b000);
    irq_src = 3'b001; tick();
    checks++; if (pending !== 3'b001) begin failures++; $display("FAIL single_pend got=%b exp=001", pending); end
    instr_done = 1'b1; next_pc = 32'h20; tick();
    checks++; if (int_take !== 1'b1) begin failures++; $display("FAIL single_take got=%0b exp=1", int_take); end
    checks++; if (int_vector !== 32'h100) begin failures++; $display("FAIL single_vec got=%h exp=100", int_vector); end
    checks++; if (active_level !== 2'd1) begin failures++; $display("FAIL single_active got=%0d exp=1", active_level); end
    checks++; if (ret_pc !== 32'h20) begin failures++; $display("FAIL single_ret got=%h exp=20", ret_pc); end
    checks++; if (pending !== 3'b000) begin failures++; $display("FAIL single_pclr got=%b exp=000", pending); end
    eret = 1'b1; tick(); idle();
    checks++; if (int_take !== 1'b0) begin failures++; $display("FAIL take_pulse got=%0b exp=0", int_take); end
    checks++; if (active_level !== 2'd1) begin failures++; $display("FAIL take_ign_eret got=%0d exp=1", active_level); end
    checks++; if (ret_pc !== 32'h20) begin failures++; $display("FAIL take_ign_ret got=%h exp=20", ret_pc); end
  endtask

  task automatic test_nesting();
    do_reset(3'b000);
    irq_src = 3'b001; tick();
    instr_done = 1'b1; next_pc = 32'h20; tick(); idle(); tick();
    irq_src = 3'b101; tick();
    checks++; if (pending !== 3'b100) begin failures++; $display("FAIL nest_pend got=%b exp=100", pending); end
    instr_done = 1'b1; next_pc = 32'h108; tick(); idle();
    checks++; if (int_take !== 1'b1) begin failures++; $display("FAIL nest_take got=%0b exp=1", int_take); end
    checks++; if (int_vector !== 32'h180) begin failures++; $display("FAIL nest_vec got=%h exp=180", int_vector); end
    checks++; if (active_level !== 2'd3) begin failures++; $display("FAIL nest_active got=%0d exp=3", active_level); end
    tick();
    instr_done = 1'b1; eret = 1'b1; #1;
    checks++; if (ret_pc !== 32'h108) begin failures++; $display("FAIL nest_eret_ret got=%h exp=108", ret_pc); end
    tick(); idle();
    checks++; if (active_level !== 2'd1) begin failures++; $display("FAIL nest_pop_active got=%0d exp=1", active_level); end
    checks++; if (ret_pc !== 32'h20) begin failures++; $display("FAIL nest_pop_ret got=%h exp=20", ret_pc); end
    instr_done = 1'b1; eret = 1'b1; tick(); idle();
    checks++; if (active_level !== 2'd0) begin failures++; $display("FAIL nest_pop2_active got=%0d exp=0", active_level); end
    checks++; if (ret_pc !== 32'h0) begin failures++; $display("FAIL nest_pop2_ret got=%h exp=0", ret_pc); end
  endtask

  task automatic test_priority();
    do_reset(3'b000);
    irq_src = 3'b011; tick();
    checks++; if (pending !== 3'b011) begin failures++; $display("FAIL prio_pend got=%b exp=011", pending); end
    instr_done = 1'b1; next_pc = 32'h40; tick(); idle();
    checks++; if (int_vector !== 32'h140) begin failures++; $display("FAIL prio_vec got=%h exp=140", int_vector); end
    checks++; if (active_level !== 2'd2) begin failures++; $display("FAIL prio_active got=%0d exp=2", active_level); end
    checks++; if (pending !== 3'b001) begin failures++; $display("FAIL prio_left got=%b exp=001", pending); end
    tick();
    instr_done = 1'b1; next_pc = 32'h44; tick(); idle();
    checks++; if (int_take !== 1'b0) begin failures++; $display("FAIL prio_nolower got=%0b exp=0", int_take); end
    instr_done = 1'b1; eret = 1'b1; tick(); idle();
    checks++; if (active_level !== 2'd0) begin failures++; $display("FAIL prio_eret got=%0d exp=0", active_level); end
    instr_done = 1'b1; next_pc = 32'h50; tick(); idle();
    checks++; if (int_take !== 1'b1) begin failures++; $display("FAIL prio_take1 got=%0b exp=1", int_take); end
    checks++; if (int_vector !== 32'h100) begin failures++; $display("FAIL prio_vec1 got=%h exp=100", int_vector); end
    checks++; if (pending !== 3'b000) begin failures++; $display("FAIL prio_pend1 got=%b exp=000", pending); end
  endtask

  task automatic test_ie_block();
    do_reset(3'b000);
    ie = 1'b0; irq_src = 3'b010; tick();
    checks++; if (pending !== 3'b010) begin failures++; $display("FAIL ie_pend got=%b exp=010", pending); end
    instr_done = 1'b1; next_pc = 32'h60; tick(); idle();
    checks++; if (int_take !== 1'b0) begin failures++; $display("FAIL ie_block got=%0b exp=0", int_take); end
    checks++; if (active_level !== 2'd0) begin failures++; $display("FAIL ie_active got=%0d exp=0", active_level); end
    ie = 1'b1; instr_done = 1'b1; next_pc = 32'h64; tick(); idle();
    checks++; if (int_take !== 1'b1) begin failures++; $display("FAIL ie_take got=%0b exp=1", int_take); end
    checks++; if (int_vector !== 32'h140) begin failures++; $display("FAIL ie_vec got=%h exp=140", int_vector); end
    checks++; if (ret_pc !== 32'h64) begin failures++; $display("FAIL ie_ret got=%h exp=64", ret_pc); end
  endtask

  task automatic test_reset_held();
    do_reset(3'b111);
    tick();
    checks++; if (pending !== 3'b000) begin failures++; $display("FAIL held_pend got=%b exp=000", pending); end
    irq_src = 3'b000; tick();
    instr_done = 1'b1; eret = 1'b1; tick(); idle();
    checks++; if (active_level !== 2'd0) begin failures++; $display("FAIL empty_eret_act got=%0d exp=0", active_level); end
    checks++; if (ret_pc !== 32'h0) begin failures++; $display("FAIL empty_eret_ret got=%h exp=0", ret_pc); end
    checks++; if (int_take !== 1'b0) begin failures++; $display("FAIL empty_eret_take got=%0b exp=0", int_take); end
    instr_done = 1'b1; next_pc = 32'h70; tick(); idle();
    checks++; if (int_take !== 1'b0) begin failures++; $display("FAIL held_notake got=%0b exp=0", int_take); end
  endtask

  task automatic test_eret_vs_pending();
    do_reset(3'b000);
    irq_src = 3'b001; tick();
    instr_done = 1'b1; next_pc = 32'h20; tick(); idle(); tick();
    irq_src = 3'b011; tick();
    instr_done = 1'b1; eret = 1'b1; next_pc = 32'h90; tick(); idle();
    checks++; if (int_take !== 1'b0) begin failures++; $display("FAIL ev_take got=%0b exp=0", int_take); end
    checks++; if (active_level !== 2'd0) begin failures++; $display("FAIL ev_active got=%0d exp=0", active_level); end
    checks++; if (pending !== 3'b010) begin failures++; $display("FAIL ev_pend got=%b exp=010", pending); end
    instr_done = 1'b1; next_pc = 32'h94; tick(); idle();
    checks++; if (int_take !== 1'b1) begin failures++; $display("FAIL ev_take2 got=%0b exp=1", int_take); end
    checks++; if (int_vector !== 32'h140) begin failures++; $display("FAIL ev_vec got=%h exp=140", int_vector); end
    checks++; if (active_level !== 2'd2) begin failures++; $display("FAIL ev_active2 got=%0d exp=2", active_level); end
  endtask

  task automatic test_set_wins();
    do_reset(3'b000);
    irq_src = 3'b001; tick();
    irq_src = 3'b000; tick();
    irq_src = 3'b001; instr_done = 1'b1; next_pc = 32'hA0; tick(); idle();
    checks++; if (int_take !== 1'b1) begin failures++; $display("FAIL setwin_take got=%0b exp=1", int_take); end
    checks++; if (pending !== 3'b001) begin failures++; $display("FAIL setwin_pend got=%b exp=001", pending); end
  endtask

  task automatic test_rst_in_take();
    do_reset(3'b000);
    irq_src = 3'b100; tick();
    instr_done = 1'b1; next_pc = 32'hB0; tick(); idle();
    checks++; if (int_take !== 1'b1) begin failures++; $display("FAIL rtake_pre got=%0b exp=1", int_take); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (int_take !== 1'b0) begin failures++; $display("FAIL rtake_take got=%0b exp=0", int_take); end
    checks++; if (active_level !== 2'd0) begin failures++; $display("FAIL rtake_active got=%0d exp=0", active_level); end
    checks++; if (int_vector !== 32'h0) begin failures++; $display("FAIL rtake_vec got=%h exp=0", int_vector); end
    checks++; if (ret_pc !== 32'h0) begin failures++; $display("FAIL rtake_ret got=%h exp=0", ret_pc); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; irq_src = '0; ie = 1'b1; instr_done = 1'b0; eret = 1'b0; next_pc = '0;
    test_reset();
    test_single_take();
    test_nesting();
    test_priority();
    test_ie_block();
    test_reset_held();
    test_eret_vs_pending();
    test_set_wins();
    test_rst_in_take();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
